// File: rtl/mv_avg_rr_sched.sv
// Purpose : time-multiplexed moving average over NUM_CH sample streams, one shared history RAM.
// Latency : grant in cycle G -> avg_valid in cycle G+3; one grant per 3 cycles aggregate.
// Backpr. : no output backpressure; inputs held until req_ready (one-hot, IDLE only).
// Ports   : clk/rst (sync, active-high); req_valid/req_data/req_ready per-channel request
//           bus; flush per-channel window clear; avg_data/avg_ch/avg_valid result strobe.
// Option  : define MV_AVG_RR_SCHED_ROUND_EN for round-half-up output instead of floor.
module mv_avg_rr_sched #(
  parameter int DATA_WIDTH   = 16,
  parameter int LOG2_AVG_LEN = 5,
  parameter int LOG2_NUM_CH  = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [(1<<LOG2_NUM_CH)-1:0]               req_valid,
  input  logic [(1<<LOG2_NUM_CH)*DATA_WIDTH-1:0]    req_data,
  output logic [(1<<LOG2_NUM_CH)-1:0]               req_ready,
  input  logic [(1<<LOG2_NUM_CH)-1:0]               flush,
  output logic [DATA_WIDTH-1:0]                     avg_data,
  output logic [LOG2_NUM_CH-1:0]                    avg_ch,
  output logic                                      avg_valid
);

  localparam int NUM_CH  = 1 << LOG2_NUM_CH;
  localparam int AVG_LEN = 1 << LOG2_AVG_LEN;
  localparam int TW      = DATA_WIDTH + LOG2_AVG_LEN;

  typedef enum logic [1:0] {IDLE, RD, UPD} state_t;

  state_t                                 state;
  logic [LOG2_NUM_CH-1:0]                 rr_ptr;
  logic [NUM_CH-1:0]                      flush_pend;
  logic [NUM_CH-1:0][LOG2_AVG_LEN-1:0]    wptr;
  logic [NUM_CH-1:0]                      full;
  logic signed [TW-1:0]                   total [NUM_CH];
  logic signed [DATA_WIDTH-1:0]           sample_q;
  logic [LOG2_NUM_CH-1:0]                 ch_q;

  logic signed [DATA_WIDTH-1:0]           mem [NUM_CH*AVG_LEN];
  logic signed [DATA_WIDTH-1:0]           rd_data;

  logic [NUM_CH-1:0]                      pend_all;
  logic [NUM_CH-1:0]                      elig;
  logic                                   gnt_found;
  logic                                   gnt_vld;
  logic [LOG2_NUM_CH-1:0]                 gnt_idx;
  logic [LOG2_NUM_CH-1:0]                 scan_idx;

  logic signed [TW-1:0]                   new_ext;
  logic signed [TW-1:0]                   old_ext;
  logic signed [TW-1:0]                   total_next;
  logic signed [DATA_WIDTH-1:0]           avg_next;

  // Round-robin search starting at rr_ptr. Any pending flush (registered or
  // arriving now) blocks every grant so the clear lands before new samples.
  always_comb begin
    pend_all  = flush_pend | flush;
    elig      = req_valid & ~flush_pend;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = rr_ptr + LOG2_NUM_CH'(i);
      if (!gnt_found && elig[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign gnt_vld = (state == IDLE) && !rst && (pend_all == '0) && gnt_found;

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // Oldest sample only counts once the channel's ring has wrapped.
  always_comb begin
    new_ext    = {{LOG2_AVG_LEN{sample_q[DATA_WIDTH-1]}}, sample_q};
    old_ext    = full[ch_q] ? {{LOG2_AVG_LEN{rd_data[DATA_WIDTH-1]}}, rd_data} : '0;
    total_next = total[ch_q] + new_ext - old_ext;
`ifdef MV_AVG_RR_SCHED_ROUND_EN
    avg_next   = DATA_WIDTH'((total_next + (TW'(1) <<< (LOG2_AVG_LEN - 1))) >>> LOG2_AVG_LEN);
`else
    avg_next   = DATA_WIDTH'(total_next >>> LOG2_AVG_LEN);
`endif
  end

  // History RAM: read the slot about to be overwritten at grant time, so the
  // registered data is ready by UPD; write the new sample back in UPD.
  always_ff @(posedge clk) begin
    if (gnt_vld) rd_data <= mem[{gnt_idx, wptr[gnt_idx]}];
    if (!rst && state == UPD) mem[{ch_q, wptr[ch_q]}] <= sample_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      flush_pend <= '0;
      wptr       <= '0;
      full       <= '0;
      sample_q   <= '0;
      ch_q       <= '0;
      avg_valid  <= 1'b0;
      avg_data   <= '0;
      avg_ch     <= '0;
      for (int c = 0; c < NUM_CH; c++) total[c] <= '0;
    end else begin
      avg_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|pend_all) begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (pend_all[c]) begin
                total[c] <= '0;
                wptr[c]  <= '0;
                full[c]  <= 1'b0;
              end
            end
            flush_pend <= '0;
          end else if (gnt_vld) begin
            sample_q <= req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            ch_q     <= gnt_idx;
            rr_ptr   <= gnt_idx + 1'b1;
            state    <= RD;
          end
        end
        RD: begin
          flush_pend <= flush_pend | flush;
          state      <= UPD;
        end
        UPD: begin
          // A flush seen during RD/UPD is only recorded; the in-flight
          // update still completes and the clear happens in IDLE.
          flush_pend  <= flush_pend | flush;
          total[ch_q] <= total_next;
          wptr[ch_q]  <= wptr[ch_q] + 1'b1;
          if (&wptr[ch_q]) full[ch_q] <= 1'b1;
          avg_data    <= avg_next;
          avg_ch      <= ch_q;
          avg_valid   <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mv_avg_rr_sched.md
# mv_avg_rr_sched

Time-multiplexed moving-average engine for NUM_CH independent sample streams. A round-robin scheduler grants one channel at a time. It then reads that channel's oldest sample from a shared history RAM and updates that channel's running total. Finally it emits the windowed average tagged with the channel index. It sits between per-antenna/per-path sample sources and downstream power or threshold logic, replacing NUM_CH separate FIFO-based averagers.

## Interface
- DATA_WIDTH, 16, sample width, signed two's complement
- LOG2_AVG_LEN, 5, window length = 2^LOG2_AVG_LEN, 1..8
- LOG2_NUM_CH, 2, channel count NUM_CH = 2^LOG2_NUM_CH
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_CH  per-channel sample valid
- req_data  in  NUM_CH*DATA_WIDTH  samples; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_CH  one-hot grant; sample accepted when req_valid[c] & req_ready[c]
- flush  in  NUM_CH  per-channel pulse: clear that channel's window
- avg_data  out  DATA_WIDTH  signed average
- avg_ch  out  LOG2_NUM_CH  channel of avg_data
- avg_valid  out  1  one-cycle strobe

## Operation
- Per-channel state:
  - total[c]: signed, TW = DATA_WIDTH+LOG2_AVG_LEN bits.
  - wptr[c]: LOG2_AVG_LEN bits.
  - full[c]: 1 bit.
- Shared history RAM: NUM_CH*2^LOG2_AVG_LEN words, address {c, wptr[c]}, 1-cycle registered read. Contents are undefined after reset and are never used while full[c]=0.
- FSM has three states: IDLE, RD, UPD.
  - IDLE → RD on a grant. Stays in IDLE otherwise.
  - RD → UPD unconditionally.
  - UPD → IDLE unconditionally.
- Grant (IDLE only):
  - Eligible channels: req_valid[c]=1 and flush_pend[c]=0.
  - Search order starts at rr_ptr and wraps. The first eligible channel gets req_ready high for that cycle.
  - On grant: capture the data, issue the RAM read, and set rr_ptr = granted+1 mod NUM_CH.
  - req_ready is 0 in RD and UPD.
- UPD:
  - new = sign-extend(sample) to TW bits.
  - old = full[c] ? sign-extend(RAM data) : 0.
  - total[c] += new − old.
  - Write sample to {c, wptr[c]}; wptr[c]++ (wraps).
  - When wptr[c] wraps 2^L−1 → 0, set full[c].
  - Register avg_data = total_next >>> LOG2_AVG_LEN (arithmetic), avg_ch = c, avg_valid = 1.
- Before the window fills, the divisor is still 2^L, so the output ramps up.
- No overflow is possible: |total| ≤ 2^L·2^(DATA_WIDTH−1).
- Flush:
  - flush[c] sets flush_pend[c] in any state.
  - In IDLE, all pending flushes are applied: total, wptr and full cleared, flush_pend cleared. No grant is issued to any channel that cycle.
  - Flush arriving while channel c is in RD/UPD: the in-flight update completes and its output is emitted. The clear is applied at the next IDLE.

## Timing
- Reset values: req_ready=0, avg_valid=0, avg_data=0, avg_ch=0.
- Reset internal state: rr_ptr=0; all totals, wptrs, full and flush_pend = 0; FSM=IDLE.
- Grant at cycle G → avg_valid high at G+3.
- FSM is in IDLE at G+3, so the next grant can occur at G+3. Peak throughput is 1 sample / 3 cycles aggregate.
- A requester must hold req_valid and req_data stable until it sees req_ready; no sample may be dropped.
- rst asserted in RD or UPD: the in-flight sample is discarded, no avg_valid is issued, and all state is cleared the next cycle.
- Simultaneous req_valid and flush on the same channel in IDLE: the flush applies and there is no grant. The sample is granted later and averaged from the cleared state.

## Configuration
- MV_AVG_RR_SCHED_ROUND_EN defined: avg_data = (total_next + 2^(LOG2_AVG_LEN−1)) >>> LOG2_AVG_LEN, computed in TW bits (round half up, cannot overflow).
- Undefined: plain arithmetic shift (floor).

## Test plan
- Ch0 only, constant 100, 40 samples, L=5, floor build → outputs floor(100k/32): 3, 6, 9, …; output 100 from sample 32 onward; avg_ch=0 every time.
- Ch1 single sample −1 → avg_data = −1 (floor); with MV_AVG_RR_SCHED_ROUND_EN → 0.
- All 4 channels hold req_valid continuously → grants in order 0,1,2,3,0,…; each req_ready pulse 3 cycles apart; avg_ch sequence matches; per-channel averages independent.
- Ch2 fed 1000 × 40, then flush[2], then one 1000 → that output = 31 (floor 1000/32); outputs of other channels unchanged.
- flush[3] and req_valid[3] in the same IDLE cycle → no req_ready that cycle; grant next IDLE; output = floor(sample/32).
- rst asserted during UPD of ch0 → no avg_valid; after release, sample 500 on ch0 → avg_data = 15.
